// File: rtl/apb_master_bridge_if.sv
// Request/response and APB signal bundle for apb_master_bridge.
// The master modport is the bridge's view. The slave modport is the view of
// everything around it: the requesting core and the APB slave.
interface apb_master_bridge_if #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    // Core-side request/response
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BUS_WIDTH-1:0]  req_wdata;
    logic                  rsp_valid;
    logic [BUS_WIDTH-1:0]  rsp_rdata;
    logic                  rsp_err;

    // APB side
    logic [ADDR_WIDTH-1:0] M_PADDR;
    logic                  M_PWRITE;
    logic                  M_PSELx;
    logic                  M_PENABLE;
    logic [BUS_WIDTH-1:0]  M_PWDATA;
    logic [BUS_WIDTH-1:0]  M_PRDATA;
    logic                  M_PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, M_PRDATA, M_PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, M_PRDATA, M_PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: converts one outstanding valid/ready request into APB
// SETUP/ACCESS phases, waits on PREADY and returns read data, or an error
// if the slave stalls for TIMEOUT_CYCLES ACCESS cycles (0 disables the timeout).
module apb_master_bridge #(
    parameter int unsigned BUS_WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    apb_master_bridge_if.master bus
);
    // Counter just wide enough to hold TIMEOUT_CYCLES; at least one bit.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value on the last stalled ACCESS cycle before the timeout fires.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic                  pwrite_q,    pwrite_d;
    logic [BUS_WIDTH-1:0]  pwdata_q,    pwdata_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  timeout_hit;

    // A stalled ACCESS cycle that would bring the counter to TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Next-state and next-output logic for the transfer sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // req_ready is high in IDLE, so req_valid alone means accept.
                if (bus.req_valid) begin
                    paddr_d  = bus.req_addr;
                    pwrite_d = bus.req_write;
                    pwdata_d = bus.req_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Only a definite 1 completes; 0, X or Z all count as wait.
                if (bus.M_PREADY == 1'b1) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.M_PRDATA;
                    rsp_err_d   = 1'b0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    cnt_d       = cnt_q + 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset discards any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.M_PADDR   = paddr_q;
    assign bus.M_PWRITE  = pwrite_q;
    assign bus.M_PSELx   = psel_q;
    assign bus.M_PENABLE = penable_q;
    assign bus.M_PWDATA  = pwdata_q;
endmodule
